uart_tx: RTL
============

# uart_tx

UART transmitter for the joystick driver's UART controller, sending 8-bit frames on `txd`. It shares the free-running 16× oversample tick that clocks the receive path: one tick every 326 `clk50` cycles, about 153.4 kHz, so 16 ticks ≈ one 9600-baud bit. Bytes come in through a valid/ready handshake and are serialised LSB-first as start, 8 data bits, optional parity, then stop bits.

## Interface
- `STOP_BITS`, default 1: number of stop bits per frame. Legal values are 1 and 2.
- `OVERSAMPLE`, default 16: ticks per bit period.
- `clk50` in 1: system clock, 50 MHz.
- `nreset` in 1: reset, asynchronous, active-low.
- `tick` in 1: single-cycle oversample strobe from the tick generator.
- `tx_data` in 8: byte to send. Sampled only on the accept cycle.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_ready` out 1: transmitter can accept a byte. High only in IDLE.
- `txd` out 1: serial line, idles high. Registered output.
- `busy` out 1: a frame is in progress, i.e. state ≠ IDLE.

## Operation
- Reset values: state IDLE, `txd`=1, `tx_ready`=1, `busy`=0, tick counter 0, bit index 0, shift register 0.
- Accept: the rising edge where `tx_valid & tx_ready` is high.
  - `tx_data` loads into the shift register.
  - Tick counter and bit index clear.
  - State moves to START.
- `tx_valid` may drop without a handshake; this has no effect. Holding `tx_valid` high with new data sends frames back-to-back.
- States:
  - IDLE: `txd`=1. Leave on accept.
  - START: `txd`=0.
  - DATA: `txd` = shift register bit 0.
  - PARITY (macro only): `txd` = even parity of the latched byte.
  - STOP: `txd`=1.
- Bit advance: every `tick` increments the tick counter. When a tick arrives with the counter at OVERSAMPLE−1, the current bit ends and the counter wraps to 0. At each bit end:
  - START goes to DATA.
  - DATA shifts the register right and increments the bit index. After index 7, go to PARITY if compiled in, otherwise STOP.
  - PARITY goes to STOP.
  - STOP counts STOP_BITS bit periods, then returns to IDLE.
- Ticks outside a frame are ignored. A tick on the accept cycle is ignored; counting starts with the next tick.
- Reset mid-frame: `txd` goes high immediately (asynchronously) and the frame is abandoned. Nothing resumes after reset.
- Counter width: $clog2(OVERSAMPLE). Bit index width: 3 bits.

## Timing
- Accept to `txd` falling: 1 cycle, since `txd` is registered.
- The start bit lasts from acceptance to the 16th following tick, i.e. 15–16 tick periods. The <1/16-bit alignment error is accepted.
- Every later bit is exactly OVERSAMPLE ticks long.
- `tx_ready` rises in the cycle after the final STOP tick, and the next accept can happen in that same cycle. Minimum gap between frames is therefore 0 idle bits plus 1–2 cycles.
- All outputs change only on `clk50` edges. No combinational path from `tx_valid` to `tx_ready`.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in, and frames carry one even-parity bit after data bit 7 (8E1/8E2).
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; frames are 8N1 or 8N2.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_OVERSAMPLE` = 16, which is the default for OVERSAMPLE.
- Single module, no sub-module. The tick generator is instantiated at the uartController level and its `tick` is shared with the receiver.

## Test plan
- Reset: hold `nreset`=0 → `txd`=1, `tx_ready`=1, `busy`=0. Ticks during reset have no effect.
- Send 0xA5, no parity, STOP_BITS=1, real tick generator → `txd` sequence 0,1,0,1,0,0,1,0,1,1. Each bit after the start bit lasts 16×326 = 5216 cycles. `tx_ready` stays low until the cycle after the stop bit's 16th tick.
- Back-to-back: hold `tx_valid`=1 and send 0x00 then 0xFF → the second start bit begins within 2 cycles of the first stop bit ending. Line reads 0,00000000,1,0,11111111,1.
- `UART_TX_PARITY_EN` with 0xA5 → parity bit 0. With 0x01 → parity bit 1. Frame is 11 bits; with STOP_BITS=2 it is 12 bits, stop held high for 32 ticks.
- Reset mid-frame: assert `nreset`=0 during data bit 3 → `txd`=1 asynchronously. After release, `tx_ready`=1 and a new 0x3C frame transmits correctly.
- Handshake edges:
  - `tx_valid` pulsed while `busy` → ignored; that byte is never transmitted.
  - A tick coincident with accept → start bit still spans 16 subsequent ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg: shared UART types and constants for the joystick UART controller.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx: 8-bit LSB-first UART transmitter paced by a shared oversample tick.
// Optional even parity bit enabled with macro UART_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk50,
    input  logic       nreset,
    input  logic       tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int               CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    uart_tx_state_t            state;
    logic [CNT_W-1:0]          tick_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic                      parity;
`endif

    // txd is loaded with the value of the bit being entered, so it is registered.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (tx_valid) begin
                state    <= START;
                txd      <= 1'b0;
                tx_ready <= 1'b0;
                busy     <= 1'b1;
                tick_cnt <= '0;
                bit_idx  <= '0;
                shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
                parity   <= ^tx_data;
`endif
            end
        end else if (tick) begin
            if (tick_cnt != CNT_LAST) begin
                tick_cnt <= tick_cnt + 1'b1;
            end else begin
                tick_cnt <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                    DATA: begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= parity;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd <= shreg[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state   <= STOP;
                        txd     <= 1'b1;
                        bit_idx <= '0;
                    end
`endif
                    // bit_idx wrapped to 0 on leaving DATA and now counts stop bits.
                    STOP: begin
                        if (bit_idx == STOP_LAST) begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            txd      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        txd      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
